// File: rtl/spmv_operand_packer_pkg.sv
// Shared definitions for the SpMV operand packer and the level-1 decode.
package spmv_operand_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned LANE_W = 8;

  // Lane i of a k-lane group occupies [LANE_W*k-1-LANE_W*i -: LANE_W]; lane 0 is the MSB lane.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned lane);
    return LANE_W * (k - 1 - lane);
  endfunction

endpackage

// File: rtl/spmv_operand_packer_if.sv
// Element stream in, packed operand group out.
interface spmv_operand_packer_if #(
  parameter int unsigned k     = 4,
  parameter int unsigned COL_W = 4
);
  logic                                           nz_valid;
  logic                                           nz_ready;
  logic [spmv_operand_packer_pkg::LANE_W-1:0]     nz_val;
  logic [COL_W-1:0]                               nz_col;
  logic                                           nz_row_end;
  logic                                           nz_last;

  logic                                           grp_valid;
  logic                                           grp_ready;
  logic [spmv_operand_packer_pkg::LANE_W*k-1:0]   matrix_in;
  logic [spmv_operand_packer_pkg::LANE_W*k-1:0]   vector_in;
  logic [k-1:0]                                   IPV;

  // Producer of elements / consumer of groups.
  modport master (
    output nz_valid, nz_val, nz_col, nz_row_end, nz_last,
    input  nz_ready,
    input  grp_valid, matrix_in, vector_in, IPV,
    output grp_ready
  );

  // The packer itself.
  modport slave (
    input  nz_valid, nz_val, nz_col, nz_row_end, nz_last,
    output nz_ready,
    output grp_valid, matrix_in, vector_in, IPV,
    input  grp_ready
  );
endinterface

// File: rtl/spmv_vec_buffer.sv
// Dense vector store: synchronous write, combinational read, out-of-range reads return 0 with a flag.
module spmv_vec_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_oor
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_oor;
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;

  // Address range decode and combinational read.
  always_comb begin
    w_wr_oor = (32'(i_waddr) >= DEPTH);
    o_oor    = (32'(i_raddr) >= DEPTH);
    w_widx   = IDX_W'(i_waddr);
    w_ridx   = IDX_W'(i_raddr);
    o_rdata  = o_oor ? '0 : r_mem[w_ridx];
  end

  // Register file write; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && !w_wr_oor) begin
      r_mem[w_widx] <= i_wdata;
    end
  end
endmodule

// File: rtl/spmv_operand_packer.sv
// Gathers vector operands for compressed nonzeros and packs k lanes per output group.
module spmv_operand_packer
  import spmv_operand_packer_pkg::*;
#(
  parameter int unsigned k         = 4,
  parameter int unsigned VEC_DEPTH = 16,
  parameter int unsigned COL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  vec_wr_en,
  input  logic [COL_W-1:0]      vec_wr_addr,
  input  logic [LANE_W-1:0]     vec_wr_data,
  spmv_operand_packer_if.slave  bus,
  output logic                  done,
  output logic                  col_err
);
  localparam int unsigned CNT_W = (k > 1) ? $clog2(k) : 1;
  localparam int unsigned GRP_W = LANE_W * k;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LANE_W-1:0]  r_pk_val [k];
  logic [LANE_W-1:0]  r_pk_vec [k];
  logic [k-1:0]       r_pk_flag;
  logic [GRP_W-1:0]   r_mat;
  logic [GRP_W-1:0]   r_vec;
  logic [k-1:0]       r_ipv;
  logic               r_grp_valid;
  logic               r_done;
  logic               r_col_err;

  logic               w_vbuf_we;
  logic [LANE_W-1:0]  w_rd_data;
  logic               w_rd_oor;
  logic               w_slot_free;
  logic               w_closing;
  logic               w_ready;
  logic               w_accept;
  logic               w_close;
  logic               w_flag;
  logic [GRP_W-1:0]   w_grp_mat;
  logic [GRP_W-1:0]   w_grp_vec;
  logic [k-1:0]       w_grp_ipv;

  assign w_vbuf_we = vec_wr_en && (r_state == ST_IDLE);

  spmv_vec_buffer #(
    .DEPTH  (VEC_DEPTH),
    .ADDR_W (COL_W),
    .DATA_W (LANE_W)
  ) u_vbuf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_vbuf_we),
    .i_waddr (vec_wr_addr),
    .i_wdata (vec_wr_data),
    .i_raddr (bus.nz_col),
    .o_rdata (w_rd_data),
    .o_oor   (w_rd_oor)
  );

  // Handshake decode and assembly of the group that would close on this edge.
  always_comb begin
    w_slot_free = !r_grp_valid || bus.grp_ready;
    w_closing   = (r_cnt == CNT_W'(k - 1)) || bus.nz_last;
    // An element that closes a group (full lane or nz_last) is only taken when the
    // output register can load it, so a short final group never overwrites a pending one.
    w_ready     = (r_state == ST_PACK) && (w_slot_free || !w_closing);
    w_accept    = bus.nz_valid && w_ready;
    w_close     = w_accept && w_closing;
    w_flag      = bus.nz_row_end || bus.nz_last;
    w_grp_mat   = '0;
    w_grp_vec   = '0;
    w_grp_ipv   = '0;
    // Lanes above r_cnt are still zero in the pack buffer, which yields the padding.
    for (int unsigned i = 0; i < k; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_grp_mat[lane_lsb(k, i) +: LANE_W] = bus.nz_val;
        w_grp_vec[lane_lsb(k, i) +: LANE_W] = w_rd_data;
        w_grp_ipv[k-1-i]                    = w_flag;
      end else begin
        w_grp_mat[lane_lsb(k, i) +: LANE_W] = r_pk_val[i];
        w_grp_vec[lane_lsb(k, i) +: LANE_W] = r_pk_vec[i];
        w_grp_ipv[k-1-i]                    = r_pk_flag[i];
      end
    end
  end

  // FSM, pack buffer and registered output group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pk_flag   <= '0;
      r_mat       <= '0;
      r_vec       <= '0;
      r_ipv       <= '0;
      r_grp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_col_err   <= 1'b0;
      for (int unsigned i = 0; i < k; i++) begin
        r_pk_val[i] <= '0;
        r_pk_vec[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_PACK;
            r_col_err <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_PACK: begin
          if (w_accept && bus.nz_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_grp_valid && bus.grp_ready) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept && w_rd_oor) begin
        r_col_err <= 1'b1;
      end

      if (w_close) begin
        r_mat       <= w_grp_mat;
        r_vec       <= w_grp_vec;
        r_ipv       <= w_grp_ipv;
        r_grp_valid <= 1'b1;
      end else if (r_grp_valid && bus.grp_ready) begin
        r_mat       <= '0;
        r_vec       <= '0;
        r_ipv       <= '0;
        r_grp_valid <= 1'b0;
      end

      if (w_close) begin
        r_cnt     <= '0;
        r_pk_flag <= '0;
        for (int unsigned i = 0; i < k; i++) begin
          r_pk_val[i] <= '0;
          r_pk_vec[i] <= '0;
        end
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        for (int unsigned i = 0; i < k; i++) begin
          if (r_cnt == CNT_W'(i)) begin
            r_pk_val[i]  <= bus.nz_val;
            r_pk_vec[i]  <= w_rd_data;
            r_pk_flag[i] <= w_flag;
          end
        end
      end
    end
  end

  assign bus.nz_ready  = w_ready;
  assign bus.grp_valid = r_grp_valid;
  assign bus.matrix_in = r_mat;
  assign bus.vector_in = r_vec;
  assign bus.IPV       = r_ipv;
  assign done          = r_done;
  assign col_err       = r_col_err;
endmodule
